// File: rtl/infer_sequencer_pkg.sv
// Shared types and constants for the inference-core sequencer: state encoding,
// RAM depths, load-mode selectors and the default stage watchdog limit.
package cnn_ctrl_pkg;

  localparam int DATA_DEPTH      = 64;
  localparam int WEIGHT_DEPTH    = 54;
  localparam logic MODE_DATA     = 1'b0;
  localparam logic MODE_WEIGHT   = 1'b1;
  localparam int TIMEOUT_DEFAULT = 255;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONV,
    ST_POOL,
    ST_CONN,
    ST_DONE,
    ST_ERR
  } state_e;

endpackage

// File: rtl/load_addr_counter.sv
// Byte-stream write address generator for one RAM; raises ready after a full
// DEPTH-byte fill and drops it on the first byte of the next fill.
module load_addr_counter
  import cnn_ctrl_pkg::*;
#(
  parameter int DEPTH = DATA_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wen,
  input  logic                     flush,
  output logic [$clog2(DEPTH)-1:0] addr,
  output logic                     ready
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [AW-1:0] addr_q, addr_d;
  logic          ready_q, ready_d;

  // A full counter sits at address 0, so a reload naturally restarts there.
  always_comb begin
    addr_d  = addr_q;
    ready_d = ready_q;
    if (flush) begin
      addr_d  = '0;
      ready_d = 1'b0;
    end else if (wen) begin
      if (addr_q == LAST) begin
        addr_d  = '0;
        ready_d = 1'b1;
      end else begin
        addr_d  = addr_q + AW'(1);
        ready_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      ready_q <= ready_d;
    end
  end

  assign addr  = addr_q;
  assign ready = ready_q;

endmodule

// File: rtl/infer_sequencer.sv
// Load/run controller for the 8x8 inference core: RAM load addressing in IDLE,
// then conv -> pool -> connect launch with a per-stage watchdog.
module infer_sequencer
  import cnn_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            mode,
  input  logic                            ram_en,
  input  logic                            calc_en,
  input  logic                            err_clr,
  input  logic                            conv_fin,
  input  logic                            pool_fin,
  input  logic                            connect_fin,
  output logic                            data_ram_en,
  output logic [$clog2(DATA_DEPTH)-1:0]   data_ram_waddr,
  output logic                            weight_ram_en,
  output logic [$clog2(WEIGHT_DEPTH)-1:0] weight_ram_waddr,
  output logic                            conv_en,
  output logic                            pool_en,
  output logic                            connect_en,
  output logic                            out_data_flag,
  output logic                            busy,
  output logic                            err
);

  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  state_e         state_q;
  logic [WDW-1:0] wd_q;
  logic           conv_en_q, pool_en_q, connect_en_q, out_flag_q, busy_q, err_q;
  logic           data_ready, weight_ready, start, err_leave, wd_expired;

  assign data_ram_en   = ram_en & (mode == MODE_DATA)   & (state_q == ST_IDLE);
  assign weight_ram_en = ram_en & (mode == MODE_WEIGHT) & (state_q == ST_IDLE);
  assign start         = (state_q == ST_IDLE) & calc_en & data_ready & weight_ready;
  assign err_leave     = (state_q == ST_ERR) & err_clr;
  assign wd_expired    = (wd_q == WD_LAST);

  // Starting a run consumes the data frame; weights stay loaded across frames.
  load_addr_counter #(.DEPTH(DATA_DEPTH)) u_data_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .wen   (data_ram_en),
    .flush (start | err_leave),
    .addr  (data_ram_waddr),
    .ready (data_ready)
  );

  load_addr_counter #(.DEPTH(WEIGHT_DEPTH)) u_weight_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .wen   (weight_ram_en),
    .flush (1'b0),
    .addr  (weight_ram_waddr),
    .ready (weight_ready)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      wd_q         <= '0;
      conv_en_q    <= 1'b0;
      pool_en_q    <= 1'b0;
      connect_en_q <= 1'b0;
      out_flag_q   <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      conv_en_q    <= 1'b0;
      pool_en_q    <= 1'b0;
      connect_en_q <= 1'b0;
      out_flag_q   <= 1'b0;
      wd_q         <= wd_q + WDW'(1);
      case (state_q)
        ST_IDLE: if (start) begin
          state_q   <= ST_CONV;
          conv_en_q <= 1'b1;
          busy_q    <= 1'b1;
          wd_q      <= '0;
        end
        // A fin arriving on the last watchdog cycle still advances the stage.
        ST_CONV: if (conv_fin) begin
          state_q   <= ST_POOL;
          pool_en_q <= 1'b1;
          wd_q      <= '0;
        end else if (wd_expired) begin
          state_q <= ST_ERR;
          err_q   <= 1'b1;
        end
        ST_POOL: if (pool_fin) begin
          state_q      <= ST_CONN;
          connect_en_q <= 1'b1;
          wd_q         <= '0;
        end else if (wd_expired) begin
          state_q <= ST_ERR;
          err_q   <= 1'b1;
        end
        ST_CONN: if (connect_fin) begin
          state_q    <= ST_DONE;
          out_flag_q <= 1'b1;
        end else if (wd_expired) begin
          state_q <= ST_ERR;
          err_q   <= 1'b1;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        ST_ERR: if (err_clr) begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          err_q   <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          err_q   <= 1'b0;
        end
      endcase
    end
  end

  assign conv_en       = conv_en_q;
  assign pool_en       = pool_en_q;
  assign connect_en    = connect_en_q;
  assign out_data_flag = out_flag_q;
  assign busy          = busy_q;
  assign err           = err_q;

endmodule

// File: doc/infer_sequencer.md
# infer_sequencer

Single controller for the 8×8 inference core. It owns the load phase: byte-stream address generation for the data RAM (64 B) and the weight RAM (54 B), plus per-RAM "loaded" tracking. It owns the run phase: ordered conv → pool → connect stage launch with per-stage watchdog, and the result strobe. It sits between the chip pins (mode/ram_en/calc_en) and the RAMs and compute modules, and replaces separate mux-and-control glue with one state machine.

## Interface
- DATA_DEPTH, 64, data RAM bytes per frame
- WEIGHT_DEPTH, 54, weight RAM bytes (conv 27 + connect 27)
- MODE_DATA, 0, `mode` value selecting the data RAM
- MODE_WEIGHT, 1, `mode` value selecting the weight RAM
- TIMEOUT, 255, max cycles a stage may run before error
- clk  in  1  core clock
- rst_n  in  1  reset; one clock; asynchronous and active-low
- mode  in  1  load target select
- ram_en  in  1  one byte valid on `din` this cycle (din goes straight to the RAMs)
- calc_en  in  1  start request (level sampled each cycle)
- err_clr  in  1  leave ERR state
- conv_fin / pool_fin / connect_fin  in  1 each  stage done pulses
- data_ram_en  out  1  data RAM write enable
- data_ram_waddr  out  $clog2(DATA_DEPTH)  data write address
- weight_ram_en  out  1  weight RAM write enable
- weight_ram_waddr  out  $clog2(WEIGHT_DEPTH)  weight write address
- conv_en / pool_en / connect_en  out  1 each  stage start pulses
- out_data_flag  out  1  result valid pulse (dout stable)
- busy  out  1  state ∉ {IDLE}
- err  out  1  state == ERR

## Operation
- States: IDLE, CONV, POOL, CONN, DONE, ERR. Reset → IDLE.
- Load, only in IDLE:
  - `data_ram_en = ram_en & (mode==MODE_DATA) & IDLE` (combinational).
  - The weight side mirrors this with MODE_WEIGHT.
  - Each RAM has an address counter. It increments after every accepted write.
  - On the write at DEPTH-1 the counter wraps to 0 and sets `X_ready`.
  - The first accepted write while `X_ready`=1 clears `X_ready` and writes address 0. A reload therefore never mixes old and new contents.
  - Counters are independent. Switching `mode` mid-load keeps each counter's position.
- ram_en outside IDLE: no write enable, counters unchanged.
- Start: in IDLE, `calc_en & data_ready & weight_ready` → CONV. Otherwise calc_en is ignored.
  - The start consumes the frame: data_ready clears.
  - weight_ready persists, so further frames need only data reloads.
- Stage states:
  - On entry, the state's enable is high for exactly one cycle and the watchdog counter clears.
  - Matching fin → next state: CONV→POOL→CONN→DONE.
  - Non-matching fin is ignored.
- DONE: out_data_flag high one cycle → IDLE.
- Watchdog:
  - Counts cycles in a stage state.
  - Reaching TIMEOUT without the matching fin → ERR.
  - fin and timeout in the same cycle: fin wins.
- ERR: all enables low. err_clr → IDLE, clearing data_ready and the data counter. The weight state is kept.

## Timing
- Reset values:
  - State IDLE.
  - All *_en, out_data_flag, busy and err are 0.
  - Both waddr are 0.
  - Both ready flags are 0.
- Registered outputs: stage enables, out_data_flag, busy, err. Combinational: RAM write enables. Addresses come straight from the counter registers.
- calc_en sampled at edge t → conv_en high in cycle t+1, busy high from t+1.
- fin sampled at edge t → next enable high in cycle t+1.
- connect_fin at edge t → out_data_flag high in cycle t+1 → busy low at t+2. calc_en is accepted again at t+2.
- Minimum frame, all fins returning the cycle after their enable: 7 cycles from calc_en to out_data_flag.
- Watchdog: with conv_en in cycle 1 and no fin, err rises in cycle 1+TIMEOUT.
- An asynchronous reset mid-run aborts immediately. All loaded flags are lost, and both RAMs must be reloaded.

## Structure
- Package `cnn_ctrl_pkg` holds:
  - the state enum
  - DATA_DEPTH / WEIGHT_DEPTH
  - the MODE_* constants
  - the default TIMEOUT
- Sub-module `load_addr_counter` (parameter DEPTH):
  - inputs: wen, flush
  - outputs: addr, ready
  - instantiated twice.

## Test plan
- Load 64 data and 54 weight bytes interleaved by mode → waddr sequences are 0..63 and 0..53 and both ready flags are set. Then calc_en → conv_en in cycle +1; with fins echoed one cycle later, out_data_flag appears 7 cycles after calc_en.
- Load only 63 data bytes, then calc_en → no conv_en and busy stays 0. The 64th byte followed by calc_en starts the run.
- Second frame: reload only 64 data bytes, then calc_en → run starts without a weight reload. The data counter restarts at address 0.
- Hold conv_fin low → err=1 exactly TIMEOUT cycles after conv_en, with no pool_en. err_clr → IDLE, and data_ready=0 while weight_ready=1.
- ram_en pulses during POOL → data_ram_en and weight_ram_en stay 0 and the counters are unchanged. A pool_fin during CONV is ignored.
- rst_n low during CONN → all outputs 0 asynchronously and the ready flags clear. After release, calc_en is ignored until both RAMs are reloaded.
